// File: rtl/multi_chan_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_chan_readout
//  Brief    : Round-robin multi-channel event readout into a FWFT output FIFO.
//             Each event is a header word, howmany channel words and, when
//             TRAILER_EN is defined, a trailer word holding the event count.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_chan_readout #(
    parameter int CHAN    = 8,
    parameter int WIDTH   = 16,
    parameter int SIZE    = 8,
    parameter int FIFO_AW = 9,
    parameter int BC_W    = 12
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CHAN-1:0]         CH_RDY,
    input  logic [WIDTH*CHAN-1:0]   CH_DATA,
    input  logic [SIZE-1:0]         howmany,
    output logic [CHAN-1:0]         CH_RD,
    input  logic                    RD_EN,
    output logic [WIDTH-1:0]        DOUT,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    BUSY
);

    localparam int c_CW    = $clog2(CHAN);
    localparam int c_HW    = 1 + c_CW + BC_W;
    localparam int c_DEPTH = 2 ** FIFO_AW;
    localparam int c_SW    = ((SIZE > FIFO_AW + 1) ? SIZE : FIFO_AW + 1) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
`ifdef TRAILER_EN
    localparam logic [1:0] c_TRL  = 2'd3;
    localparam logic [1:0] c_POST = c_TRL;
`else
    localparam logic [1:0] c_POST = c_IDLE;
`endif

    logic [1:0]          r_state;
    logic [BC_W-1:0]     r_bc;
    logic [c_CW-1:0]     r_sel;
    logic [c_CW-1:0]     r_start;
    logic [SIZE-1:0]     r_hm;
    logic [SIZE-1:0]     r_cnt;
    logic                r_rd_d;
    logic [FIFO_AW:0]    r_wptr;
    logic [FIFO_AW:0]    r_rptr;
    logic [WIDTH-1:0]    r_mem [c_DEPTH];
`ifdef TRAILER_EN
    logic [15:0]         r_evcnt;
`endif

    logic                w_found;
    logic [c_CW-1:0]     w_pick;
    logic [c_CW-1:0]     w_next;
    logic [FIFO_AW:0]    w_count;
    logic [c_SW-1:0]     w_free;
    logic [c_SW-1:0]     w_need;
    logic                w_start;
    logic                w_strobe;
    logic                w_we;
    logic                w_re;
    logic [WIDTH-1:0]    w_wdata;

    // Round-robin search beginning at the channel after the last one served
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < CHAN; i++) begin
            j = (int'(r_start) + i) % CHAN;
            if (!w_found && CH_RDY[j]) begin
                w_found = 1'b1;
                w_pick  = c_CW'(j);
            end
        end
    end

    assign w_next  = (w_pick == c_CW'(CHAN - 1)) ? '0 : w_pick + 1'b1;
    assign w_count = r_wptr - r_rptr;
    assign w_free  = c_SW'(c_DEPTH) - c_SW'(w_count);
    // Reserve header + trailer slots even when no trailer is built
    assign w_need  = c_SW'(howmany) + c_SW'(2);
    assign w_start = w_found && (w_free >= w_need);

    assign w_strobe = (r_state == c_DATA) && (r_cnt < r_hm);

    always_comb begin
        CH_RD = '0;
        if (w_strobe) begin
            CH_RD[r_sel] = 1'b1;
        end
    end

    // Channel word lands one cycle after its strobe, so it never collides
    // with the header or trailer write
    always_comb begin
        w_we    = 1'b0;
        w_wdata = '0;
        if (r_rd_d) begin
            w_we    = 1'b1;
            w_wdata = CH_DATA[int'(r_sel) * WIDTH +: WIDTH];
        end else if (r_state == c_HDR) begin
            w_we                = 1'b1;
            w_wdata[c_HW-1:0]   = {1'b1, r_sel, r_bc};
        end
`ifdef TRAILER_EN
        else if (r_state == c_TRL) begin
            w_we    = 1'b1;
            w_wdata = WIDTH'(r_evcnt);
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_IDLE;
            r_bc    <= '0;
            r_sel   <= '0;
            r_start <= '0;
            r_hm    <= '0;
            r_cnt   <= '0;
            r_rd_d  <= 1'b0;
`ifdef TRAILER_EN
            r_evcnt <= '0;
`endif
        end else begin
            r_bc   <= r_bc + 1'b1;
            r_rd_d <= w_strobe;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state <= c_HDR;
                        r_sel   <= w_pick;
                        r_start <= w_next;
                        r_hm    <= howmany;
                        r_cnt   <= '0;
                    end
                end
                c_HDR: begin
                    r_state <= (r_hm == '0) ? c_POST : c_DATA;
                end
                c_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Extra cycle at r_cnt == r_hm absorbs the last channel word
                    if (r_cnt == r_hm) begin
                        r_state <= c_POST;
                    end
                end
`ifdef TRAILER_EN
                c_TRL: begin
                    r_state <= c_IDLE;
                    r_evcnt <= r_evcnt + 1'b1;
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign w_re = RD_EN && !EMPTY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_re) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= w_wdata;
        end
    end

    assign DOUT  = r_mem[r_rptr[FIFO_AW-1:0]];
    assign EMPTY = (w_count == '0);
    assign FULL  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign BUSY  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_chan_readout
//  Brief    : Scoreboard bench for multi_chan_readout (8 channels, 16-deep FIFO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_chan_readout;

    localparam int c_CHAN = 8;
    localparam int c_W    = 16;
    localparam int c_SIZE = 8;
    localparam int c_AW   = 4;
    localparam int c_BCW  = 12;
`ifdef TRAILER_EN
    localparam int c_TRL  = 1;
`else
    localparam int c_TRL  = 0;
`endif

    logic                    CLK = 1'b0;
    logic                    RST = 1'b0;
    logic [c_CHAN-1:0]       CH_RDY;
    logic [c_W*c_CHAN-1:0]   CH_DATA;
    logic [c_SIZE-1:0]       howmany;
    logic [c_CHAN-1:0]       CH_RD;
    logic                    RD_EN;
    logic [c_W-1:0]          DOUT;
    logic                    FULL;
    logic                    EMPTY;
    logic                    BUSY;

    multi_chan_readout #(
        .CHAN(c_CHAN), .WIDTH(c_W), .SIZE(c_SIZE), .FIFO_AW(c_AW), .BC_W(c_BCW)
    ) dut (
        .CLK(CLK), .RST(RST), .CH_RDY(CH_RDY), .CH_DATA(CH_DATA),
        .howmany(howmany), .CH_RD(CH_RD), .RD_EN(RD_EN), .DOUT(DOUT),
        .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          strobes[c_CHAN];
    int          ev_num = 0;
    logic [11:0] m_bc;

    function automatic logic [15:0] chval(int i);
        return 16'h5A00 + 16'(i * 17);
    endfunction

    // Reference bunch-crossing counter
    always @(posedge CLK or negedge RST) begin
        if (!RST) m_bc <= '0;
        else      m_bc <= m_bc + 1'b1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_event(int ch, int hm, logic [11:0] bc, bit bc_chk);
        exp_t e;
        e.data = {1'b1, 3'(ch), bc};
        e.mask = bc_chk ? 16'hFFFF : 16'hF000;
        q.push_back(e);
        for (int k = 0; k < hm; k++) begin
            e.data = chval(ch);
            e.mask = 16'hFFFF;
            q.push_back(e);
        end
        if (c_TRL != 0) begin
            e.data = 16'(ev_num);
            e.mask = 16'hFFFF;
            q.push_back(e);
        end
        ev_num++;
    endtask

    task automatic do_reset();
        RST    = 1'b0;
        CH_RDY = '0;
        q.delete();
        ev_num = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while (BUSY && n < bound) begin
            @(posedge CLK); #1;
            n++;
        end
        check("idle_timeout", BUSY, 0);
    endtask

    task automatic wait_drain(int bound);
        int n = 0;
        RD_EN = 1'b1;
        while ((q.size() != 0 || !EMPTY) && n < bound) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain_left", q.size(), 0);
    endtask

    // Monitor: one-hot strobe check and FIFO scoreboard
    always @(negedge CLK) begin
        if (RST) begin
            if (CH_RD != '0) begin
                checks++;
                if ($countones(CH_RD) != 1) begin
                    errors++;
                    $display("FAIL ch_rd_onehot got %b expected one bit", CH_RD);
                end
            end
            for (int i = 0; i < c_CHAN; i++) begin
                if (CH_RD[i]) strobes[i]++;
            end
            if (RD_EN && !EMPTY) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h expected none", DOUT);
                end else begin
                    mon_e = q.pop_front();
                    if ((DOUT & mon_e.mask) !== (mon_e.data & mon_e.mask)) begin
                        errors++;
                        $display("FAIL fifo_word got %h expected %h mask %h",
                                 DOUT, mon_e.data, mon_e.mask);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int per;
        int n;
        logic [11:0] b;

        for (int i = 0; i < c_CHAN; i++) begin
            strobes[i] = 0;
            CH_DATA[i*c_W +: c_W] = chval(i);
        end
        CH_RDY  = '0;
        howmany = '0;
        RD_EN   = 1'b0;
        do_reset();

        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ch_rd", CH_RD, 0);

        // Single event from channel 2
        RD_EN   = 1'b1;
        s0      = strobes[2];
        howmany = 8'd3;
        CH_RDY  = 8'h04;
        push_event(2, 3, m_bc + 12'd1, 1'b1);
        @(posedge CLK); #1;
        check("busy_start_ch2", BUSY, 1);
        CH_RDY = '0;
        wait_idle(40);
        wait_drain(40);
        check("strobes_ch2", strobes[2] - s0, 3);

        // Round-robin between channels 0 and 7
        do_reset();
        RD_EN   = 1'b1;
        howmany = 8'd1;
        CH_RDY  = 8'h81;
        per     = 1 + 3 + c_TRL;
        b       = m_bc;
        push_event(0, 1, b + 12'(1), 1'b1);
        push_event(7, 1, b + 12'(1 + per), 1'b1);
        push_event(0, 1, b + 12'(1 + 2 * per), 1'b1);
        push_event(7, 1, b + 12'(1 + 3 * per), 1'b1);
        repeat (3 * per + 1) @(posedge CLK);
        #1 CH_RDY = '0;
        wait_idle(40);
        wait_drain(40);

        // Zero-length event: header (and trailer) only
        s0 = 0;
        for (int i = 0; i < c_CHAN; i++) s0 += strobes[i];
        howmany = 8'd0;
        CH_RDY  = 8'h01;
        push_event(0, 0, m_bc + 12'd1, 1'b1);
        @(posedge CLK); #1;
        check("busy_start_hm0", BUSY, 1);
        CH_RDY = '0;
        wait_idle(20);
        wait_drain(20);
        n = 0;
        for (int i = 0; i < c_CHAN; i++) n += strobes[i];
        check("strobes_hm0", n - s0, 0);

        // Backpressure: FIFO fills, FSM waits until space is freed
        RD_EN   = 1'b0;
        howmany = 8'd6;
        CH_RDY  = 8'hFF;
        per     = 6 + 3 + c_TRL;
        b       = m_bc;
        push_event(1, 6, b + 12'(1), 1'b1);
        push_event(2, 6, b + 12'(1 + per), 1'b1);
        repeat (per + 1) @(posedge CLK);
        #1 CH_RDY = 8'h08;
        push_event(3, 6, 12'd0, 1'b0);
        repeat (per + 3) @(posedge CLK);
        #1;
        check("bp_full", FULL, c_TRL);
        check("bp_busy_wait", BUSY, 0);
        check("bp_not_empty", EMPTY, 0);
        RD_EN = 1'b1;
        repeat (8) @(posedge CLK);
        #1 RD_EN = 1'b0;
        n = 0;
        while (!BUSY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("bp_third_start", BUSY, 1);
        CH_RDY = '0;
        wait_idle(40);
        wait_drain(60);

        // Asynchronous reset in the middle of a long event
        RD_EN   = 1'b0;
        howmany = 8'd10;
        CH_RDY  = 8'h10;
        @(posedge CLK); #1;
        CH_RDY = '0;
        repeat (3) @(posedge CLK);
        #2;
        check("mid_ch_rd_before", CH_RD, 8'h10);
        #1 RST = 1'b0;
        #1;
        check("mid_rst_ch_rd", CH_RD, 0);
        check("mid_rst_empty", EMPTY, 1);
        check("mid_rst_busy", BUSY, 0);
        q.delete();
        ev_num = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        check("post_rst_empty", EMPTY, 1);
        howmany = 8'd1;
        CH_RDY  = 8'h41;
        RD_EN   = 1'b1;
        push_event(0, 1, m_bc + 12'd1, 1'b1);
        @(posedge CLK); #1;
        CH_RDY = '0;
        wait_idle(20);
        wait_drain(20);

        // Bunch-crossing wrap
        do_reset();
        RD_EN = 1'b1;
        repeat (4096 + 5) @(posedge CLK);
        #1;
        howmany = 8'd2;
        CH_RDY  = 8'h20;
        push_event(5, 2, 12'd6, 1'b1);
        @(posedge CLK); #1;
        CH_RDY = '0;
        wait_idle(20);
        wait_drain(20);

        check("final_queue", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
